// File: rtl/vrased_nregion_guard.sv
// vrased_nregion_guard: NREG-region access guard with SMEM atomicity FSM and stretched violation reset.
// Define VRASED_CAUSE_LOG_EN to keep the viol_cause/viol_cnt telemetry registers; otherwise both read 0.
module vrased_nregion_guard #(
  parameter int                 NREG        = 2,
  parameter logic [NREG*16-1:0] REG_BASE    = {16'h0400, 16'h6A00},
  parameter logic [NREG*16-1:0] REG_SIZE    = {16'h0C00, 16'h0020},
  parameter logic [NREG-1:0]    REG_RD_PROT = 2'b01,
  parameter logic [15:0]        SMEM_BASE   = 16'hA000,
  parameter logic [15:0]        SMEM_SIZE   = 16'h4000,
  parameter logic [15:0]        SMEM_ENTRY  = 16'hA000,
  parameter logic [15:0]        SMEM_EXIT   = 16'hDFFE,
  parameter int                 RST_HOLD    = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [15:0]    pc,
  input  logic           data_en,
  input  logic           data_wr,
  input  logic [15:0]    data_addr,
  input  logic           dma_en,
  input  logic [15:0]    dma_addr,
  input  logic           irq,
  output logic           reset,
  output logic [NREG+3:0] viol_cause,
  output logic [7:0]     viol_cnt
);
  typedef enum logic [1:0] {RUN, TRUSTED, HOLD} state_t;
  localparam logic [16:0] SB = {1'b0, SMEM_BASE};
  localparam logic [16:0] SE = SB + {1'b0, SMEM_SIZE};
  state_t state, nstate;
  logic [7:0] hold_cnt;
  logic [15:0] prev_pc;
  logic [NREG-1:0] cpu_hit, dma_hit;
  logic [NREG+3:0] cause;
  logic in_smem, viol;
  // 17-bit compares so a region ending at 0xFFFF does not wrap to zero
  for (genvar i = 0; i < NREG; i++) begin : g_reg
    localparam logic [16:0] B = {1'b0, REG_BASE[16*i +: 16]};
    localparam logic [16:0] E = B + {1'b0, REG_SIZE[16*i +: 16]};
    localparam bit NZ = REG_SIZE[16*i +: 16] != 16'd0;
    assign cpu_hit[i] = NZ && {1'b0, data_addr} >= B && {1'b0, data_addr} < E;
    assign dma_hit[i] = NZ && {1'b0, dma_addr} >= B && {1'b0, dma_addr} < E;
  end
  assign in_smem = {1'b0, pc} >= SB && {1'b0, pc} < SE;
  assign viol = |cause;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= RUN;
      hold_cnt <= '0;
      prev_pc <= '0;
      reset <= 1'b0;
    end else begin
      state <= nstate;
      reset <= nstate == HOLD;
      hold_cnt <= viol ? 8'(RST_HOLD - 1) : (state == HOLD && hold_cnt != 8'd0) ? hold_cnt - 8'd1 : hold_cnt;
      prev_pc <= state == HOLD ? '0 : pc;
    end
  always_comb
    nstate = viol ? HOLD :
             (state == RUN && pc == SMEM_ENTRY) ? TRUSTED :
             (state == TRUSTED && !in_smem) ? RUN :
             (state == HOLD && hold_cnt == 8'd0) ? RUN : state;
  // HOLD masks every cause so late violations neither count nor extend the pulse
  always_comb begin
    cause = '0;
    cause[NREG-1:0] = cpu_hit & {NREG{data_en}} & ({NREG{data_wr}} | REG_RD_PROT) & {NREG{!(state == TRUSTED && in_smem)}};
    cause[NREG] = dma_en && |dma_hit;
    cause[NREG+1] = state == RUN && in_smem && pc != SMEM_ENTRY;
    cause[NREG+2] = state == TRUSTED && !in_smem && prev_pc != SMEM_EXIT;
    cause[NREG+3] = state == TRUSTED && (irq || dma_en);
    cause = state == HOLD ? '0 : cause;
  end
`ifdef VRASED_CAUSE_LOG_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      viol_cause <= '0;
      viol_cnt <= '0;
    end else if (viol) begin
      viol_cause <= cause;
      viol_cnt <= viol_cnt + {7'd0, viol_cnt != 8'hFF};
    end
`else
  assign viol_cause = '0;
  assign viol_cnt = '0;
`endif
endmodule
